// File: rtl/ir_fetch_sequencer_if.sv
// rtl/ir_fetch_sequencer_if.sv - handshake bundle between the fetch sequencer and its datapath
//
// Purpose: groups the sequencer's control inputs and strobe outputs so the
// sequencer and the surrounding PC / memory / IR / execute logic connect
// through one port.
//
// Signals (direction seen from the sequencer, modport master):
//   start       in   begin or resume sequencing
//   stop        in   finish current instruction, then go idle
//   mem_ack     in   instruction memory data valid
//   ir_opcode   in   opcode bits from the IR output
//   exec_done   in   execute datapath finished
//   mem_rd      out  memory read request (level)
//   ir_write    out  IR load strobe
//   ir_read     out  IR output enable
//   pc_inc      out  PC increment strobe
//   exec_start  out  execute start pulse
//   busy        out  sequencing an instruction
//   halted      out  stopped on a HALT opcode
//   fault       out  memory fetch timed out
//   instr_count out  retired-instruction count
interface ir_fetch_sequencer_if #(
   parameter int OPCODE_W = 8,
   parameter int CNT_W    = 16
);
   logic                start;
   logic                stop;
   logic                mem_ack;
   logic [OPCODE_W-1:0] ir_opcode;
   logic                exec_done;
   logic                mem_rd;
   logic                ir_write;
   logic                ir_read;
   logic                pc_inc;
   logic                exec_start;
   logic                busy;
   logic                halted;
   logic                fault;
   logic [CNT_W-1:0]    instr_count;

   modport master (
      input  start, stop, mem_ack, ir_opcode, exec_done,
      output mem_rd, ir_write, ir_read, pc_inc, exec_start,
             busy, halted, fault, instr_count
   );

   modport slave (
      output start, stop, mem_ack, ir_opcode, exec_done,
      input  mem_rd, ir_write, ir_read, pc_inc, exec_start,
             busy, halted, fault, instr_count
   );
endinterface

// File: rtl/ir_fetch_sequencer.sv
// rtl/ir_fetch_sequencer.sv - fetch / IR load / decode / execute control FSM
//
// Purpose: walks one instruction at a time through FETCH, IR_LOAD, DECODE
// and EXECUTE, counts retired instructions, parks in HALT on the halt opcode
// and in FAULT when memory never acknowledges a fetch.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   ir_fetch_sequencer_if.master - control inputs and strobe outputs
module ir_fetch_sequencer #(
   parameter int                  OPCODE_W = 8,
   parameter logic [OPCODE_W-1:0] HALT_OP  = {OPCODE_W{1'b1}},
   parameter int                  TIMEOUT  = 16,
   parameter int                  CNT_W    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   ir_fetch_sequencer_if.master    bus
);

   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_IR_LOAD = 3'd2,
      S_DECODE  = 3'd3,
      S_EXECUTE = 3'd4,
      S_HALT    = 3'd5,
      S_FAULT   = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               stop_pend_q, stop_pend_d;
   logic               done_early_q, done_early_d;

   logic               mem_rd_q;
   logic               ir_write_q;
   logic               ir_read_q;
   logic               pc_inc_q;
   logic               decode_q;
   logic               busy_q;
   logic               halted_q;
   logic               fault_q;

   logic               is_halt_op;
   logic               retire;

   assign is_halt_op = (bus.ir_opcode == HALT_OP);
   // exec_done may arrive while still in DECODE; it is remembered so the
   // first EXECUTE cycle retires the instruction.
   assign retire     = bus.exec_done | done_early_q;

   always_comb begin
      state_d      = state_q;
      tmo_d        = tmo_q;
      cnt_d        = cnt_q;
      stop_pend_d  = stop_pend_q;
      done_early_d = done_early_q;
      case (state_q)
         S_IDLE: begin
            stop_pend_d  = 1'b0;
            done_early_d = 1'b0;
            if (bus.start) begin
               state_d = S_FETCH;
               tmo_d   = '0;
            end
         end
         S_FETCH: begin
            if (bus.stop) stop_pend_d = 1'b1;
            // an acknowledge on the last allowed cycle still wins
            if (bus.mem_ack) begin
               state_d = S_IR_LOAD;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               state_d = S_FAULT;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_IR_LOAD: begin
            if (bus.stop) stop_pend_d = 1'b1;
            done_early_d = 1'b0;
            state_d      = S_DECODE;
         end
         S_DECODE: begin
            if (bus.stop) stop_pend_d = 1'b1;
            if (is_halt_op) begin
               state_d = S_HALT;
            end else begin
               done_early_d = bus.exec_done;
               state_d      = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            if (retire) begin
               cnt_d        = cnt_q + CNT_W'(1);
               done_early_d = 1'b0;
               if (bus.stop || stop_pend_q) begin
                  state_d     = S_IDLE;
                  stop_pend_d = 1'b0;
               end else begin
                  state_d = S_FETCH;
                  tmo_d   = '0;
               end
            end else if (bus.stop) begin
               stop_pend_d = 1'b1;
            end
         end
         S_HALT: begin
            if (bus.start) begin
               state_d = S_FETCH;
               tmo_d   = '0;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d     = S_IDLE;
            stop_pend_d = 1'b0;
         end
      endcase
   end

   // Outputs are registered from the next state, so each one is a clean
   // decode of the state held for the whole cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tmo_q        <= '0;
         cnt_q        <= '0;
         stop_pend_q  <= 1'b0;
         done_early_q <= 1'b0;
         mem_rd_q     <= 1'b0;
         ir_write_q   <= 1'b0;
         ir_read_q    <= 1'b0;
         pc_inc_q     <= 1'b0;
         decode_q     <= 1'b0;
         busy_q       <= 1'b0;
         halted_q     <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         cnt_q        <= cnt_d;
         stop_pend_q  <= stop_pend_d;
         done_early_q <= done_early_d;
         mem_rd_q     <= (state_d == S_FETCH);
         ir_write_q   <= (state_d == S_IR_LOAD);
         pc_inc_q     <= (state_d == S_IR_LOAD);
         ir_read_q    <= (state_d == S_DECODE) || (state_d == S_EXECUTE);
         decode_q     <= (state_d == S_DECODE);
         busy_q       <= (state_d == S_FETCH)  || (state_d == S_IR_LOAD) ||
                         (state_d == S_DECODE) || (state_d == S_EXECUTE);
         halted_q     <= (state_d == S_HALT);
         fault_q      <= (state_d == S_FAULT);
      end
   end

   assign bus.mem_rd      = mem_rd_q;
   assign bus.ir_write    = ir_write_q;
   assign bus.ir_read     = ir_read_q;
   assign bus.pc_inc      = pc_inc_q;
   // IR contents are stable through DECODE, so gating by opcode keeps the
   // pulse valid for the whole cycle and suppresses it for HALT.
   assign bus.exec_start  = decode_q & ~is_halt_op;
   assign bus.busy        = busy_q;
   assign bus.halted      = halted_q;
   assign bus.fault       = fault_q;
   assign bus.instr_count = cnt_q;

endmodule
